// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-port controller: FSM states, access size codes,
// byte reversal and the alignment rule.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUS_I,
    BUS_D,
    RESP_I,
    RESP_D
  } busState_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Size code 2'b11 is treated exactly like a word.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: byte enables, store replication and load extract/extend.
// Define MEM_BUS_ENDIAN_SWAP_EN to byte-reverse bus data (big-endian CPU view).
module mem_lane_fmt
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sgn,
  input  logic [31:0] storeData,
  input  logic [31:0] busData,
  output logic [3:0]  byteEnable,
  output logic [31:0] busWriteData,
  output logic [31:0] fetchData,
  output logic [31:0] loadData
);

  logic [31:0] replicated;
  logic [31:0] cpuWord;
  logic [1:0]  byteSel;
  logic        halfHi;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteEnable   = 4'b1111;
    replicated   = storeData;
    cpuWord      = busData;
    busWriteData = storeData;
    byteSel      = offset;
    halfHi       = offset[1];
    byteVal      = 8'h00;
    halfVal      = 16'h0000;
    loadData     = 32'h0;

    case (size)
      SIZE_B: begin
        byteEnable = 4'b0001 << offset;
        replicated = {4{storeData[7:0]}};
      end
      SIZE_H: begin
        byteEnable = offset[1] ? 4'b1100 : 4'b0011;
        replicated = {2{storeData[15:0]}};
      end
      default: begin
        byteEnable = 4'b1111;
        replicated = storeData;
      end
    endcase

`ifdef MEM_BUS_ENDIAN_SWAP_EN
    // After reversal, bus lane k sits at CPU byte position 3-k.
    cpuWord      = bswap32(busData);
    busWriteData = bswap32(replicated);
    byteSel      = ~offset;
    halfHi       = ~offset[1];
`else
    cpuWord      = busData;
    busWriteData = replicated;
    byteSel      = offset;
    halfHi       = offset[1];
`endif

    byteVal = cpuWord[{byteSel, 3'b000} +: 8];
    halfVal = halfHi ? cpuWord[31:16] : cpuWord[15:0];

    case (size)
      SIZE_B:  loadData = {{24{sgn & byteVal[7]}}, byteVal};
      SIZE_H:  loadData = {{16{sgn & halfVal[15]}}, halfVal};
      default: loadData = cpuWord;
    endcase
  end

  assign fetchData = cpuWord;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory-port controller: round-robin arbitration of MIPS fetch/data requests onto one
// Avalon-style bus port. Define MEM_BUS_ENDIAN_SWAP_EN for big-endian byte swapping.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  busState_t state, nextState;

  logic        lastGrantData;
  logic [1:0]  opSize;
  logic [1:0]  opOffset;
  logic        opSigned;
  logic        opWrite;
  logic        opErr;

  logic        dReq;
  logic        dMisaligned;
  logic        grantI;
  logic        grantD;

  logic [1:0]  fmtSize;
  logic [1:0]  fmtOffset;
  logic [3:0]  fmtByteEnable;
  logic [31:0] fmtWriteData;
  logic [31:0] fmtFetchData;
  logic [31:0] fmtLoadData;

  assign dReq        = d_read | d_write;
  assign dMisaligned = isMisaligned(d_size, d_addr[1:0]);

  // While idle the formatter sees the live request so bus outputs can be registered at grant;
  // afterwards it works from the latched access for load extraction.
  assign fmtSize   = (state == IDLE) ? d_size       : opSize;
  assign fmtOffset = (state == IDLE) ? d_addr[1:0]  : opOffset;

  mem_lane_fmt u_fmt (
    .size        (fmtSize),
    .offset      (fmtOffset),
    .sgn         (opSigned),
    .storeData   (d_wdata),
    .busData     (readdata),
    .byteEnable  (fmtByteEnable),
    .busWriteData(fmtWriteData),
    .fetchData   (fmtFetchData),
    .loadData    (fmtLoadData)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Ties go to whichever side was not granted last; data wins the first tie after reset.
  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    i_valid   = 1'b0;
    i_rdata   = '0;
    d_valid   = 1'b0;
    d_err     = 1'b0;
    d_rdata   = '0;

    case (state)
      IDLE: begin
        if (dReq && !(i_req && lastGrantData)) begin
          grantD    = 1'b1;
          nextState = dMisaligned ? RESP_D : BUS_D;
        end else if (i_req) begin
          grantI    = 1'b1;
          nextState = BUS_I;
        end
      end
      BUS_I: if (!waitrequest) nextState = RESP_I;
      BUS_D: if (!waitrequest) nextState = RESP_D;
      RESP_I: begin
        i_valid   = 1'b1;
        i_rdata   = fmtFetchData;
        nextState = IDLE;
      end
      RESP_D: begin
        d_valid   = 1'b1;
        d_err     = opErr;
        d_rdata   = (opErr || opWrite) ? '0 : fmtLoadData;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrantData <= 1'b0;
      opSize        <= SIZE_W;
      opOffset      <= 2'b00;
      opSigned      <= 1'b0;
      opWrite       <= 1'b0;
      opErr         <= 1'b0;
      address       <= '0;
      read          <= 1'b0;
      write         <= 1'b0;
      byteenable    <= 4'b0000;
      writedata     <= '0;
    end else begin
      if (grantD) begin
        lastGrantData <= 1'b1;
        opSize        <= d_size;
        opOffset      <= d_addr[1:0];
        opSigned      <= d_signed;
        opWrite       <= d_write;
        opErr         <= dMisaligned;
        if (!dMisaligned) begin
          address    <= d_addr & WORD_MASK;
          read       <= ~d_write;
          write      <= d_write;
          byteenable <= fmtByteEnable;
          writedata  <= d_write ? fmtWriteData : '0;
        end
      end else if (grantI) begin
        lastGrantData <= 1'b0;
        opSize        <= SIZE_W;
        opOffset      <= 2'b00;
        opSigned      <= 1'b0;
        opWrite       <= 1'b0;
        opErr         <= 1'b0;
        address       <= i_addr & WORD_MASK;
        read          <= 1'b1;
        write         <= 1'b0;
        byteenable    <= 4'b1111;
        writedata     <= '0;
      end else if ((state == BUS_I || state == BUS_D) && !waitrequest) begin
        read  <= 1'b0;
        write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus random accesses checked
// against a lane-level memory model (honours MEM_BUS_ENDIAN_SWAP_EN).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  int assertCount = 0;
  int failCount   = 0;

`ifdef MEM_BUS_ENDIAN_SWAP_EN
  localparam bit BIG_ENDIAN = 1'b1;
`else
  localparam bit BIG_ENDIAN = 1'b0;
`endif

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_valid    (i_valid),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_size     (d_size),
    .d_signed   (d_signed),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .d_err      (d_err),
    .address    (address),
    .read       (read),
    .write      (write),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  // Reference model: memory is four byte lanes; an access of n bytes covers lanes off..off+n-1.
  function automatic int sizeBytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit modelMisaligned(input logic [31:0] addr, input logic [1:0] size);
    return (addr % sizeBytes(size)) != 0;
  endfunction

  function automatic logic [3:0] modelByteEnable(input logic [31:0] addr, input logic [1:0] size);
    int n = sizeBytes(size);
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] modelStoreLanes(input logic [31:0] wdata, input logic [1:0] size);
    int n = sizeBytes(size);
    logic [31:0] lanes = '0;
    for (int l = 0; l < 4; l++) begin
      int j = l % n;
      int src = BIG_ENDIAN ? (n - 1 - j) : j;
      lanes[8*l +: 8] = wdata[8*src +: 8];
    end
    return lanes;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] lanes, input logic [31:0] addr,
                                            input logic [1:0] size, input bit sgn);
    int n = sizeBytes(size);
    int off = addr % 4;
    logic [31:0] val = '0;
    for (int j = 0; j < n; j++) begin
      int pos = BIG_ENDIAN ? (n - 1 - j) : j;
      val[8*pos +: 8] = lanes[8*(off + j) +: 8];
    end
    if (sgn && n < 4 && val[8*n - 1]) val = val | (32'hFFFF_FFFF << (8*n));
    return val;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit fetch, input bit wr, input logic [31:0] addr,
                               input logic [1:0] size, input bit sgn, input logic [31:0] wdata);
    i_req    = fetch;
    i_addr   = addr;
    d_read   = !fetch && !wr;
    d_write  = !fetch && wr;
    d_addr   = addr;
    d_size   = size;
    d_signed = sgn;
    d_wdata  = wdata;
  endtask

  task automatic idleInputs();
    i_req   = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the edge that
  // follows the completion pulse, i.e. at the earliest point a new request can be granted.
  task automatic doAccess(input bit fetch, input bit wr, input logic [31:0] addr,
                          input logic [1:0] size, input bit sgn, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits, input string tag);
    bit mis = !fetch && modelMisaligned(addr, size);
    logic [1:0] expStrobe = fetch ? 2'b10 : (wr ? 2'b01 : 2'b10);
    applyStimulus(fetch, wr, addr, size, sgn, wdata);
    @(negedge clk);
    checkOutput({tag, " idle strobes/valids"}, {28'b0, read, write, i_valid, d_valid}, 32'h0);
    if (mis) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({tag, " misaligned valid/err"}, {30'b0, d_valid, d_err}, 32'h3);
      checkOutput({tag, " misaligned rdata"}, d_rdata, 32'h0);
      checkOutput({tag, " misaligned no strobe"}, {30'b0, read, write}, 32'h0);
    end else begin
      for (int j = 0; j <= waits; j++) begin
        @(posedge clk); #1;
        waitrequest = (j < waits);
        readdata    = $urandom;
        @(negedge clk);
        checkOutput({tag, " bus strobe"}, {30'b0, read, write}, {30'b0, expStrobe});
        checkOutput({tag, " bus address"}, address, addr & 32'hFFFF_FFFC);
        checkOutput({tag, " bus byteenable"}, {28'b0, byteenable},
                    {28'b0, fetch ? 4'b1111 : modelByteEnable(addr, size)});
        if (!fetch && wr) checkOutput({tag, " bus writedata"}, writedata, modelStoreLanes(wdata, size));
        checkOutput({tag, " no early valid"}, {30'b0, i_valid, d_valid}, 32'h0);
      end
      @(posedge clk); #1;
      waitrequest = 1'b0;
      readdata    = rdata;
      @(negedge clk);
      checkOutput({tag, " resp strobes low"}, {30'b0, read, write}, 32'h0);
      if (fetch) begin
        checkOutput({tag, " i_valid/d_valid"}, {30'b0, i_valid, d_valid}, 32'h2);
        checkOutput({tag, " i_rdata"}, i_rdata, modelLoad(rdata, 32'h0, 2'b10, 1'b0));
      end else begin
        checkOutput({tag, " i_valid/d_valid/d_err"}, {29'b0, i_valid, d_valid, d_err}, 32'h2);
        if (!wr) checkOutput({tag, " d_rdata"}, d_rdata, modelLoad(rdata, addr, size, sgn));
      end
    end
    @(posedge clk); #1;
    idleInputs();
  endtask

  initial begin
    reset       = 1'b1;
    waitrequest = 1'b0;
    readdata    = '0;
    i_req       = 1'b0;
    i_addr      = '0;
    d_write     = 1'b0;
    d_signed    = 1'b0;
    d_wdata     = '0;
    applyStimulus(1'b0, 1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0);

    $display("[TB] reset with d_read held high");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset strobes", {30'b0, read, write}, 32'h0);
    checkOutput("reset address", address, 32'h0);
    checkOutput("reset byteenable", {28'b0, byteenable}, 32'h0);
    checkOutput("reset writedata", writedata, 32'h0);
    checkOutput("reset valids/err", {29'b0, i_valid, d_valid, d_err}, 32'h0);
    checkOutput("reset i_rdata", i_rdata, 32'h0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    doAccess(1'b0, 1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 0, "first read");

    $display("[TB] directed accesses");
    doAccess(1'b1, 1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'h0, 32'h7856_3412, 3, "fetch wait3");
    doAccess(1'b0, 1'b0, 32'h2000_0003, 2'b00, 1'b1, 32'h0, 32'h80FF_FFFF, 0, "lb signed");
    doAccess(1'b0, 1'b0, 32'h2000_0003, 2'b00, 1'b0, 32'h0, 32'h80FF_FFFF, 0, "lbu");
    doAccess(1'b0, 1'b1, 32'h2000_0002, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0, 1, "sh off2");
    doAccess(1'b0, 1'b0, 32'h2000_0001, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 0, "lw misaligned");
    doAccess(1'b0, 1'b0, 32'h2000_0005, 2'b01, 1'b1, 32'h0, 32'h1234_5678, 0, "lh misaligned");
    doAccess(1'b0, 1'b0, 32'h2000_0000, 2'b01, 1'b1, 32'h0, 32'h1234_8765, 2, "lh off0 signed");
    doAccess(1'b0, 1'b1, 32'h2000_0001, 2'b00, 1'b0, 32'h0000_00A5, 32'h0, 0, "sb off1");
    doAccess(1'b0, 1'b1, 32'h2000_0008, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, "sw size11");

    $display("[TB] random accesses");
    for (int k = 0; k < 60; k++) begin
      bit fetch = ($urandom_range(0, 2) == 0);
      bit wr    = $urandom_range(0, 1) == 1;
      doAccess(fetch, wr, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
               $urandom, $urandom, $urandom_range(0, 3), "random");
    end

    $display("[TB] arbitration ties and reset mid-cycle");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'h0);
    i_req  = 1'b1;
    i_addr = 32'h0000_0200;
    @(posedge clk); #1;
    waitrequest = 1'b0;
    @(negedge clk);
    checkOutput("tie1 data granted", {read, address}, {1'b1, 32'h0000_0040});
    @(posedge clk); #1;
    readdata = 32'h1111_2222;
    @(negedge clk);
    checkOutput("tie1 d_valid", {30'b0, i_valid, d_valid}, 32'h1);
    checkOutput("tie1 d_rdata", d_rdata, modelLoad(32'h1111_2222, 32'h0, 2'b10, 1'b0));
    @(posedge clk); #1;
    d_addr = 32'h0000_0044;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("tie2 instr granted", {read, address}, {1'b1, 32'h0000_0200});
    @(posedge clk); #1;
    readdata = 32'h0102_0304;
    @(negedge clk);
    checkOutput("tie2 i_valid", {30'b0, i_valid, d_valid}, 32'h2);
    checkOutput("tie2 i_rdata", i_rdata, modelLoad(32'h0102_0304, 32'h0, 2'b10, 1'b0));
    @(posedge clk); #1;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("tie3 data in BUS_D", {read, address}, {1'b1, 32'h0000_0044});
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset in BUS_D read", {31'b0, read}, 32'h0);
    checkOutput("reset in BUS_D address/be", {byteenable, address[27:0]}, 32'h0);
    idleInputs();
    waitrequest = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("after reset idle", {28'b0, read, write, i_valid, d_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
